// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery multiplier.
//   DEFAULT_WIDTH : operand / modulus width used when no override is given
//   state_t       : controller states (IDLE, LOOP, SUB, DONE)
package montgomery_pkg;

  localparam int DEFAULT_WIDTH = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/montgomery_adder.sv
// Combinational add/subtract unit for the wide Montgomery accumulator.
// No registers; the parent instantiates one copy per operation it needs.
// Ports:
//   x, y : W-bit operands
//   sub  : 1 selects x - y, 0 selects x + y
//   sum  : W-bit result (modulo 2^W; a borrow shows up in the top bit)
module montgomery_adder
  import montgomery_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH + 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] sum
);

  assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/montgomery.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// One iteration per clock over the bits of A, then a single conditional
// subtraction for full reduction. Requires M odd and A, B < M.
// Ports:
//   clk     : clock, rising edge active
//   resetn  : synchronous active-low reset
//   start   : begin a multiplication (sampled only in IDLE)
//   in_a    : multiplicand A
//   in_b    : multiplier B
//   in_m    : modulus M
//   result  : Montgomery product, held until the next operation's SUB cycle
//   done    : one-cycle pulse, WIDTH+2 edges after the edge that took start
module montgomery
  import montgomery_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  // Accumulator width: C stays below 2M, so C+B+M stays below 4M < 2^(WIDTH+2).
  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] m_reg;
  logic [XW-1:0]    c;
  logic [CW-1:0]    count;

  logic [XW-1:0]    b_ext;
  logic [XW-1:0]    m_ext;
  logic [XW-1:0]    sum_b;
  logic [XW-1:0]    sum_m;
  logic [XW-1:0]    diff;
  logic [XW-1:0]    t1;
  logic [XW-1:0]    t2;

  assign b_ext = {2'b00, b_reg};
  assign m_ext = {2'b00, m_reg};

  // C + B, taken only when the current bit of A is set.
  montgomery_adder #(.W(XW)) u_add_b (
    .x   (c),
    .y   (b_ext),
    .sub (1'b0),
    .sum (sum_b)
  );

  assign t1 = a_shift[0] ? sum_b : c;

  // Adding the odd modulus makes the partial sum even so the halving is exact.
  montgomery_adder #(.W(XW)) u_add_m (
    .x   (t1),
    .y   (m_ext),
    .sub (1'b0),
    .sum (sum_m)
  );

  assign t2 = t1[0] ? sum_m : t1;

  // Final reduction: C - M; a set sign bit means C was already below M.
  montgomery_adder #(.W(XW)) u_sub_m (
    .x   (c),
    .y   (m_ext),
    .sub (1'b1),
    .sum (diff)
  );

  // t2[0] is always zero after the odd correction, and diff[WIDTH] is never
  // needed because C < 2M keeps the difference within WIDTH bits when positive.
  logic unused_bits;
  assign unused_bits = ^{t2[0], diff[WIDTH]};

  // Controller and datapath registers. Reset wins over start in every state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      c       <= '0;
      count   <= '0;
      a_shift <= '0;
      b_reg   <= '0;
      m_reg   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_shift <= in_a;
            b_reg   <= in_b;
            m_reg   <= in_m;
            c       <= '0;
            count   <= '0;
            state   <= LOOP;
          end
        end
        LOOP: begin
          c       <= {1'b0, t2[XW-1:1]};
          a_shift <= a_shift >> 1;
          count   <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= SUB;
          end
        end
        SUB: begin
          result <= diff[XW-1] ? c[WIDTH-1:0] : diff[WIDTH-1:0];
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery.sv
// Self-checking bench for the Montgomery multiplier (WIDTH = 512).
// A reference model computes A*B mod M and then divides by two modulo M
// WIDTH times; a queue of expected completions is checked by one compare
// process every cycle (done timing, result value, result hold).
module tb_montgomery;

  localparam int W   = 512;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] value;
    int           due;
  } exp_t;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] in_m;
  logic [W-1:0] result;
  logic         done;

  int           cycle    = 0;
  int           checks   = 0;
  int           errors   = 0;
  bit           checking = 0;
  logic [W-1:0] last_exp = '0;
  exp_t         q[$];

  montgomery dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A*B*2^-W mod M: reduce the full product, then halve modulo M W times.
  function automatic logic [W-1:0] mont_model(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic [W-1:0] m);
    logic [2*W-1:0] p;
    logic [W:0]     x;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, m};
    x = {1'b0, p[W-1:0]};
    for (int i = 0; i < W; i++) begin
      if (x[0]) x = (x + {1'b0, m}) >> 1;
      else      x = x >> 1;
    end
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  // Drives one single-cycle start pulse and records when done must appear.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] m, output int due);
    exp_t e;
    @(negedge clk);
    in_a  = a;
    in_b  = b;
    in_m  = m;
    start = 1'b1;
    due   = cycle + 1 + LAT;
    e.value = mont_model(a, b, m);
    e.due   = due;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("[TB] FAIL wait_timeout: got %0d pending required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Compare process: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    cycle++;
    #1;
    if (checking) begin
      if (q.size() != 0 && cycle == q[0].due) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL done_timing: got done=%b at cycle %0d required 1", done, cycle);
        end
        checks++;
        if (result !== q[0].value) begin
          errors++;
          $display("[TB] FAIL result: got %h required %h", result, q[0].value);
        end
        last_exp = q[0].value;
        void'(q.pop_front());
      end else begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL unexpected_done: got done=%b at cycle %0d required 0", done, cycle);
        end
        if (q.size() == 0 || cycle < q[0].due - 1) begin
          checks++;
          if (result !== last_exp) begin
            errors++;
            $display("[TB] FAIL result_hold: got %h required %h", result, last_exp);
          end
        end
      end
    end
  end

  logic [W-1:0] big_m;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] rm;
  int           d;
  int           d1;
  exp_t         e2;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_m   = '0;
    repeat (3) @(negedge clk);
    resetn   = 1'b1;
    checking = 1'b1;
    $display("[TB] reset released");

    checkOutput("reset_done", {{(W-1){1'b0}}, done}, '0);
    checkOutput("reset_result", result, '0);

    // Hand-computed pins for the model itself.
    checkOutput("model_2_2_3", mont_model(2, 2, 3), 1);
    checkOutput("model_3_5_7", mont_model(3, 5, 7), 2);
    checkOutput("model_2_3_5", mont_model(2, 3, 5), 1);
    checkOutput("model_1_1_3", mont_model(1, 1, 3), 1);

    big_m = {16'hf8f6, {30{16'h1b2d}}, 16'h997d};

    // Small operands with known answers.
    applyStimulus(2, 2, 3, d);
    waitIdle();
    checkOutput("lit_2_2_3", result, 1);

    applyStimulus(3, 5, 7, d);
    waitIdle();
    checkOutput("lit_3_5_7", result, 2);

    // Zero multiplicand against a full-width modulus.
    applyStimulus('0, big_m >> 1, big_m, d);
    waitIdle();
    checkOutput("lit_zero_a", result, '0);

    // Random full-width operands.
    for (int k = 0; k < 3; k++) begin
      rm = rand_wide();
      rm[0] = 1'b1;
      rm[W-1] = 1'b1;
      ra = rand_wide() % rm;
      rb = rand_wide() % rm;
      applyStimulus(ra, rb, rm, d);
      waitIdle();
    end

    // Largest legal operands.
    applyStimulus(big_m - 1, big_m - 1, big_m, d);
    waitIdle();

    // start and input changes while busy must be ignored.
    ra = rand_wide() % big_m;
    rb = rand_wide() % big_m;
    applyStimulus(ra, rb, big_m, d);
    while (cycle < d - LAT + 100) @(negedge clk);
    in_a  = rb;
    in_b  = ra;
    in_m  = 3;
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Back-to-back: start held through SUB and DONE, accepted in the next IDLE.
    applyStimulus(3, 5, 7, d1);
    while (cycle < d1 - 2) @(negedge clk);
    in_a  = 2;
    in_b  = 3;
    in_m  = 5;
    start = 1'b1;
    e2.value = mont_model(2, 3, 5);
    e2.due   = d1 + 1 + LAT;
    q.push_back(e2);
    while (cycle < d1 + 1) @(negedge clk);
    start = 1'b0;
    waitIdle();
    checkOutput("b2b_second", result, 1);

    // Reset in the middle of LOOP, with start held during reset.
    ra = rand_wide() % big_m;
    applyStimulus(ra, big_m - 2, big_m, d);
    while (cycle < d - LAT + 200) @(negedge clk);
    resetn   = 1'b0;
    start    = 1'b1;
    q.delete();
    last_exp = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    start  = 1'b0;
    repeat (LAT + 20) @(negedge clk);
    checkOutput("abort_result", result, '0);
    checkOutput("abort_done", {{(W-1){1'b0}}, done}, '0);

    // New operation after the abort.
    applyStimulus(ra, big_m - 2, big_m, d);
    waitIdle();
    checkOutput("after_reset", result, mont_model(ra, big_m - 2, big_m));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
